ula_sequenciador: RTL and testbench
===================================

ULA_SEQUENCIADOR -- requirements
Module: ula_sequenciador

Interface
REQ-001 SHALL have parameter W, default 6, meaning operand/result width.
REQ-002 SHALL have parameter CW, default 4, meaning iteration-count width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-006 SHALL have ports cmd_sel input 4, cmd_init input W, cmd_operand input W, cmd_count input CW: opcode, initial accumulator, fixed operand, iteration count.
REQ-007 SHALL have ports alu_A output W, alu_B output W, alu_Sel output 4, alu_Reset output 1: drive side of the external 6-bit arithmetic ALU.
REQ-008 SHALL have ports alu_O input W, alu_Overflow input 1, alu_Zero input 1: combinational ALU result and flags.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-010 SHALL have ports rsp_result output W, rsp_overflow output 1, rsp_zero output 1, rsp_iters output CW: final accumulator, sticky overflow, last zero flag, iterations executed.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, RESP.
REQ-012 SHALL assert cmd_ready only in IDLE; transfer occurs when cmd_valid && cmd_ready at a rising edge.
REQ-013 SHALL on accept latch sel/operand, load acc=cmd_init, remaining=cmd_count, iters=0, ovf=0; go RUN if cmd_count!=0, else RESP with zero=(cmd_init==0).
REQ-014 SHALL in RUN drive alu_A=acc, alu_B=operand, alu_Sel=sel, alu_Reset=0; elsewhere alu_Reset=1, alu_A=alu_B=0, alu_Sel=0.
REQ-015 SHALL each RUN cycle register acc<=alu_O, zero<=alu_Zero, ovf<=ovf|alu_Overflow, iters<=iters+1, remaining<=remaining-1.
REQ-016 SHALL leave RUN for RESP on the edge where remaining==1 (last iteration captured); latency accept-to-rsp_valid = cmd_count+1 cycles (1 cycle for count 0).
REQ-017 SHALL in RESP hold rsp_valid=1 and all rsp_* stable until rsp_ready=1, then return to IDLE; rsp_valid=0 outside RESP.
REQ-018 SHALL pass cmd_sel 8..15 unchanged to the ALU (ALU default yields O=0, Zero=1) without error signalling.
REQ-019 SHALL not accept a new command in the cycle rsp handshake completes (no IDLE bypass).

Reset
REQ-020 SHALL on Reset=1 at a rising edge enter IDLE from any state, aborting RUN/RESP without response.
REQ-021 SHALL after reset hold rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_zero=0, rsp_iters=0, cmd_ready=1, alu_Reset=1.

Configuration
REQ-022 SHALL, when ULA_SEQ_STOP_ON_OVF_EN is defined, leave RUN for RESP on the edge capturing alu_Overflow=1, rsp_iters counting that iteration.
REQ-023 SHALL, when ULA_SEQ_STOP_ON_OVF_EN is undefined, run all cmd_count iterations regardless of overflow, ovf remaining sticky.

Structure
REQ-024 SHALL place state enum, W/CW defaults and opcode constants (SEL_ADD=0000, SEL_SUB=0001, SEL_ADD_INV=0010, SEL_SUB_INV=0011, SEL_INC_A=0100, SEL_DEC_A=0101, SEL_INC_B=0110, SEL_DEC_B=0111) in package ula_seq_pkg.
REQ-025 SHALL contain no sub-module; ALU instantiated beside it at parent level.

Verification
REQ-026 SHALL cover sel=0000, init=5, operand=3, count=4 -> rsp_result=17, overflow=0, zero=0, iters=4, rsp_valid 5 cycles after accept.
REQ-027 SHALL cover sel=0100, init=60, count=5 -> result=63, overflow=1; iters=4 with ULA_SEQ_STOP_ON_OVF_EN, iters=5 without.
REQ-028 SHALL cover count=0, init=0 -> rsp_valid next cycle, result=0, zero=1, iters=0, ALU never leaves reset.
REQ-029 SHALL cover sel=0101, init=2, count=3 -> result=0, zero=1, overflow=0, iters=3.
REQ-030 SHALL cover rsp_ready low 3 cycles in RESP -> rsp_* stable, cmd_ready=0; Reset pulse mid-RUN -> IDLE next cycle, rsp_valid never asserted, outputs per REQ-021.

Source files
------------

// File: rtl/ula_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | ula_seq_pkg: shared types, default widths and ALU opcodes for the        |
// | ula_sequenciador iteration sequencer.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ula_seq_pkg;

    localparam int W_DEFAULT  = 6;
    localparam int CW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SEL_ADD     = 4'b0000;
    localparam logic [3:0] SEL_SUB     = 4'b0001;
    localparam logic [3:0] SEL_ADD_INV = 4'b0010;
    localparam logic [3:0] SEL_SUB_INV = 4'b0011;
    localparam logic [3:0] SEL_INC_A   = 4'b0100;
    localparam logic [3:0] SEL_DEC_A   = 4'b0101;
    localparam logic [3:0] SEL_INC_B   = 4'b0110;
    localparam logic [3:0] SEL_DEC_B   = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/ula_sequenciador.sv
// +--------------------------------------------------------------------------+
// | ula_sequenciador: applies one ALU opcode cmd_count times to an           |
// | accumulator via an external combinational ALU, then returns the result.  |
// | Option: ULA_SEQ_STOP_ON_OVF_EN ends the run on the first overflow.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ula_sequenciador
    import ula_seq_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_sel,
    input  logic [W-1:0]  cmd_init,
    input  logic [W-1:0]  cmd_operand,
    input  logic [CW-1:0] cmd_count,
    output logic [W-1:0]  alu_A,
    output logic [W-1:0]  alu_B,
    output logic [3:0]    alu_Sel,
    output logic          alu_Reset,
    input  logic [W-1:0]  alu_O,
    input  logic          alu_Overflow,
    input  logic          alu_Zero,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_result,
    output logic          rsp_overflow,
    output logic          rsp_zero,
    output logic [CW-1:0] rsp_iters
);

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          last_iter;

    logic [3:0]    sel;
    logic [W-1:0]  operand;
    logic [W-1:0]  acc;
    logic [CW-1:0] remaining;
    logic [CW-1:0] iters;
    logic          ovf;
    logic          zero;

`ifdef ULA_SEQ_STOP_ON_OVF_EN
    assign last_iter = (remaining == CW'(1)) || alu_Overflow;
`else
    assign last_iter = (remaining == CW'(1));
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_Reset  = 1'b1;
        alu_A      = '0;
        alu_B      = '0;
        alu_Sel    = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (cmd_count != '0) ? RUN : RESP;
                end
            end
            RUN: begin
                alu_Reset = 1'b0;
                alu_A     = acc;
                alu_B     = operand;
                alu_Sel   = sel;
                if (last_iter) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                // Returning to IDLE first keeps a pending command from slipping in this cycle.
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            sel       <= '0;
            operand   <= '0;
            acc       <= '0;
            remaining <= '0;
            iters     <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            sel       <= cmd_sel;
            operand   <= cmd_operand;
            acc       <= cmd_init;
            remaining <= cmd_count;
            iters     <= '0;
            ovf       <= 1'b0;
            zero      <= (cmd_init == '0);
        end else if (state == RUN) begin
            acc       <= alu_O;
            zero      <= alu_Zero;
            ovf       <= ovf | alu_Overflow;
            iters     <= iters + CW'(1);
            remaining <= remaining - CW'(1);
        end
    end

    assign rsp_result   = acc;
    assign rsp_overflow = ovf;
    assign rsp_zero     = zero;
    assign rsp_iters    = iters;

endmodule

`default_nettype wire

// File: tb/tb_ula_sequenciador.sv
// +--------------------------------------------------------------------------+
// | tb_ula_sequenciador: bench for ula_sequenciador with a behavioural       |
// | saturating 6-bit ALU and a loop-level reference model.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ula_sequenciador;

    localparam int W  = 6;
    localparam int CW = 4;
    localparam int VW = W + CW + 2;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_sel = '0;
    logic [W-1:0]  cmd_init = '0;
    logic [W-1:0]  cmd_operand = '0;
    logic [CW-1:0] cmd_count = '0;
    logic [W-1:0]  alu_A;
    logic [W-1:0]  alu_B;
    logic [3:0]    alu_Sel;
    logic          alu_Reset;
    logic [W-1:0]  alu_O;
    logic          alu_Overflow;
    logic          alu_Zero;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_overflow;
    logic          rsp_zero;
    logic [CW-1:0] rsp_iters;
    logic [VW-1:0] obs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ula_sequenciador #(.W(W), .CW(CW)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_sel      (cmd_sel),
        .cmd_init     (cmd_init),
        .cmd_operand  (cmd_operand),
        .cmd_count    (cmd_count),
        .alu_A        (alu_A),
        .alu_B        (alu_B),
        .alu_Sel      (alu_Sel),
        .alu_Reset    (alu_Reset),
        .alu_O        (alu_O),
        .alu_Overflow (alu_Overflow),
        .alu_Zero     (alu_Zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_iters    (rsp_iters)
    );

    assign obs = {rsp_result, rsp_overflow, rsp_zero, rsp_iters};

    // Saturating helpers return {overflow, value}; subtraction clamps at 0 silently.
    function automatic logic [W:0] sat_add(input logic [W-1:0] x, input logic [W-1:0] y);
        int s;
        s = int'(x) + int'(y);
        if (s > (1 << W) - 1) return {1'b1, {W{1'b1}}};
        return {1'b0, W'(s)};
    endfunction

    function automatic logic [W:0] clamp_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        if (int'(x) < int'(y)) return '0;
        return {1'b0, W'(int'(x) - int'(y))};
    endfunction

    // Returns {O, Overflow, Zero}
    function automatic logic [W+1:0] alu_fn(input logic [3:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W:0]   r;
        logic [W-1:0] one;
        one = W'(1);
        case (s)
            4'd0:    r = sat_add(a, b);
            4'd1:    r = clamp_sub(a, b);
            4'd2:    r = sat_add(a, ~b);
            4'd3:    r = clamp_sub(b, a);
            4'd4:    r = sat_add(a, one);
            4'd5:    r = clamp_sub(a, one);
            4'd6:    r = sat_add(b, one);
            4'd7:    r = clamp_sub(b, one);
            default: r = '0;
        endcase
        return {r[W-1:0], r[W], (r[W-1:0] == '0)};
    endfunction

    always_comb begin
        if (alu_Reset) begin
            alu_O        = '0;
            alu_Overflow = 1'b0;
            alu_Zero     = 1'b1;
        end else begin
            {alu_O, alu_Overflow, alu_Zero} = alu_fn(alu_Sel, alu_A, alu_B);
        end
    end

    // Reference: iterate the opcode on a plain accumulator; returns {result, ovf, zero, iters}.
    function automatic logic [VW-1:0] model(input logic [3:0] s, input logic [W-1:0] init,
                                            input logic [W-1:0] op, input logic [CW-1:0] cnt);
        logic [W-1:0]  acc;
        logic          ov;
        logic          z;
        int            it;
        bit            done;
        logic [W+1:0]  r;
        acc  = init;
        ov   = 1'b0;
        z    = (init == '0);
        it   = 0;
        done = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            if (!done) begin
                r   = alu_fn(s, acc, op);
                acc = r[W+1:2];
                ov  = ov | r[1];
                z   = r[0];
                it++;
`ifdef ULA_SEQ_STOP_ON_OVF_EN
                if (r[1]) done = 1;
`endif
            end
        end
        return {acc, ov, z, CW'(it)};
    endfunction

    task automatic send_cmd(input logic [3:0] s, input logic [W-1:0] init, input logic [W-1:0] op,
                            input logic [CW-1:0] cnt, output int lat, output bit alu_active,
                            output bit ok);
        int n;
        @(negedge clk);
        cmd_sel     = s;
        cmd_init    = init;
        cmd_operand = op;
        cmd_count   = cnt;
        cmd_valid   = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        lat        = 1;
        alu_active = 0;
        ok         = 0;
        for (int i = 0; i < 100; i++) begin
            if (!alu_Reset) alu_active = 1;
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string name, input bit ok, input int lat, input int exp_lat,
                             input logic [VW-1:0] exp);
        total_cnt++;
        if (!ok) $display("FAIL %s rsp_valid timeout", name);
        else pass_cnt++;
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (obs !== exp) $display("FAIL %s {result,ovf,zero,iters} got %h exp %h", name, obs, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        total_cnt++;
        if ({rsp_valid, obs, cmd_ready, alu_Reset, alu_A, alu_B, alu_Sel} !==
            {1'b0, {VW{1'b0}}, 1'b1, 1'b1, {W{1'b0}}, {W{1'b0}}, 4'd0})
            $display("FAIL reset_state got v=%b obs=%h rdy=%b arst=%b", rsp_valid, obs, cmd_ready, alu_Reset);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int lat; bit act; bit ok;
        send_cmd(4'b0000, 6'd5, 6'd3, 4'd4, lat, act, ok);
        check_rsp("add_5_plus_3x4", ok, lat, 5, {6'd17, 1'b0, 1'b0, 4'd4});
        finish_rsp();
    endtask

    task automatic test_inc_ovf();
        int lat; bit act; bit ok;
        logic [CW-1:0] exp_it;
`ifdef ULA_SEQ_STOP_ON_OVF_EN
        exp_it = 4'd4;
`else
        exp_it = 4'd5;
`endif
        send_cmd(4'b0100, 6'd60, 6'd0, 4'd5, lat, act, ok);
        check_rsp("inc_a_overflow", ok, lat, int'(exp_it) + 1, {6'd63, 1'b1, 1'b0, exp_it});
        finish_rsp();
    endtask

    task automatic test_count_zero();
        int lat; bit act; bit ok;
        send_cmd(4'b0000, 6'd0, 6'd9, 4'd0, lat, act, ok);
        check_rsp("count_zero", ok, lat, 1, {6'd0, 1'b0, 1'b1, 4'd0});
        total_cnt++;
        if (act) $display("FAIL count_zero_alu_reset alu left reset got 1 exp 0");
        else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_dec();
        int lat; bit act; bit ok;
        send_cmd(4'b0101, 6'd2, 6'd0, 4'd3, lat, act, ok);
        check_rsp("dec_a_to_zero", ok, lat, 4, {6'd0, 1'b0, 1'b1, 4'd3});
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int lat; bit act; bit ok;
        logic [VW-1:0] snap;
        send_cmd(4'b0000, 6'd1, 6'd2, 4'd3, lat, act, ok);
        check_rsp("backpressure_rsp", ok, lat, 4, model(4'b0000, 6'd1, 6'd2, 4'd3));
        snap = obs;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total_cnt++;
            if (!(rsp_valid === 1'b1 && cmd_ready === 1'b0 && obs === snap))
                $display("FAIL hold_cycle%0d got v=%b rdy=%b obs=%h exp v=1 rdy=0 obs=%h",
                         i, rsp_valid, cmd_ready, obs, snap);
            else pass_cnt++;
        end
        // Offer a new command in the handshake cycle; it must not be taken.
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_count   = 4'd0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total_cnt++;
        if (!(rsp_valid === 1'b0 && cmd_ready === 1'b1))
            $display("FAIL no_idle_bypass got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, cmd_ready);
        else pass_cnt++;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        cmd_sel = 4'b0000; cmd_init = 6'd1; cmd_operand = 6'd1; cmd_count = 4'd10;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        total_cnt++;
        if ({rsp_valid, obs, cmd_ready, alu_Reset} !== {1'b0, {VW{1'b0}}, 1'b1, 1'b1})
            $display("FAIL reset_mid_run got v=%b obs=%h rdy=%b arst=%b exp 0/0/1/1",
                     rsp_valid, obs, cmd_ready, alu_Reset);
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) seen = 1;
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (seen) $display("FAIL aborted_run_rsp rsp_valid got 1 exp 0");
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat; bit act; bit ok;
        logic [3:0] s; logic [W-1:0] init; logic [W-1:0] op; logic [CW-1:0] cnt;
        logic [VW-1:0] exp;
        int exp_lat;
        for (int k = 0; k < 25; k++) begin
            s    = 4'($urandom_range(0, 15));
            init = W'($urandom);
            op   = W'($urandom);
            cnt  = CW'($urandom);
            exp  = model(s, init, op, cnt);
            exp_lat = (cnt == '0) ? 1 : int'(exp[CW-1:0]) + 1;
            send_cmd(s, init, op, cnt, lat, act, ok);
            check_rsp($sformatf("random%0d_sel%0d_cnt%0d", k, s, cnt), ok, lat, exp_lat, exp);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            finish_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_inc_ovf();
        test_count_zero();
        test_dec();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
